i2c_txn_scheduler: RTL and testbench
====================================

// Module: i2c_txn_scheduler
// PURPOSE
//  Shares one APB-attached I2C master among NREQ requesters (sensor pollers, config loaders).
//  Round-robin arbitration; the granted job is run as a scripted register sequence on the master.
//  Sequence: program NBY/ADR/TDR, start via CFG, poll CFG.done, fetch RDR, return data.
//  Sits between the requester fabric and the I2C master's APB slave port (regs 0x00-0x10).
// PARAMETERS
//  NREQ      4     number of requesters (2..8)
//  POLL_GAP  16    idle clk_i cycles between consecutive CFG status reads (>=1)
//  TMO_CYC   4096  poll cycles before abort (used only with I2C_SCHED_TIMEOUT_EN)
// PORTS
//  clk_i       in   1        system clock, all logic on posedge
//  rst_i       in   1        synchronous, active-high reset
//  req_i       in   NREQ     per-requester job request, held high until done_o pulse
//  rnw_i       in   NREQ     1=read job, 0=write job
//  dev_i       in   7*NREQ   7-bit I2C device address, slice [7k+6:7k]
//  nby_i       in   2*NREQ   byte count 1..3 (0 treated as 1)
//  wdata_i     in   32*NREQ  write payload, byte0 in [7:0]
//  gnt_o       out  NREQ     one-hot, high while requester k's job runs
//  done_o      out  NREQ     one-cycle completion pulse
//  err_o       out  NREQ     one-cycle abort pulse (only with I2C_SCHED_TIMEOUT_EN, else 0)
//  rdata_o     out  32       read result, valid in the done_o cycle, unread bytes zero
//  psel_o      out  1        APB select to I2C master
//  penable_o   out  1        APB enable
//  pwrite_o    out  1        APB write
//  paddr_o     out  8        APB byte address
//  pwdata_o    out  8        APB write data
//  prdata_i    in   8        APB read data
//  pready_i    in   1        APB ready
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, RR pointer=0, poll counter=0. Reset mid-job abandons it silently.
//  APB: every access = SETUP (psel=1, penable=0, 1 cycle), then ACCESS (psel=1, penable=1),
//   held until pready_i=1. The access completes in that cycle and prdata_i is captured then.
//   psel/penable return to 0 for >=1 cycle between accesses.
//  Arbiter: in IDLE, grant the lowest k>=ptr with req_i[k], wrapping. ptr<=k+1 mod NREQ on grant.
//   No preemption. A req_i dropped mid-job is ignored; the job completes.
//  FSM: IDLE -> WR_NBY (0x00 <= nby-1) -> WR_ADR (0x04 <= {1'b0,dev})
//   -> [write job] WR_TDR: 0x0C..0x0C+nby-1 <= payload bytes, ascending
//   -> WR_CFG (0x10 <= {6'b0,rnw,1'b1}: bit0=start, bit1=rnw) -> GAP (POLL_GAP cycles)
//   -> POLL (read 0x10). bit1 set -> read job: RD_RDR, else CLR; clear -> GAP.
//   -> RD_RDR: read 0x08..0x08+nby-1 into rdata bytes 0..nby-1 -> CLR
//   -> CLR (0x10 <= 0) -> DONE: done_o[k]=1 for 1 cycle, gnt_o drops next cycle -> IDLE.
//  Back-to-back: a new grant issues no earlier than the cycle after DONE.
//  rdata_o holds its last value until the next read-job DONE; write jobs leave it unchanged.
//  Byte counter 2 bits, counts 0..nby-1, no wrap past nby.
// CONFIGURATION
//  I2C_SCHED_TIMEOUT_EN defined:
//   A 16-bit counter is cleared at WR_CFG and incremented per POLL read.
//   At TMO_CYC reads -> CLR, then err_o[k] (not done_o) pulses and rdata_o is left unchanged.
//  Undefined: no counter. POLL repeats forever until done; err_o is tied 0.
// TESTING
//  Write: req0, dev=0x50, nby=2, wdata=0xAABB
//   -> APB writes 00<=01, 04<=50, 0C<=BB, 0D<=AA, 10<=01;
//   -> polls; done_o[0] after the 10<=00 write.
//  Read: req1, rnw=1, nby=3; model returns RDR bytes 11,22,33
//   -> rdata_o=0x00332211 with done_o[1].
//  RR fairness: req0..3 all held high continuously -> grant order 0,1,2,3,0.
//   No requester is granted twice while another waits.
//  APB stall: pready_i low for 5 cycles on every ACCESS
//   -> psel/penable held stable, addr/data unchanged; job completes correctly.
//  Reset mid-POLL: rst_i for 1 cycle
//   -> next cycle gnt/done/psel=0, ptr=0; a fresh req2 runs normally.
//  Timeout (with I2C_SCHED_TIMEOUT_EN, TMO_CYC=8): done bit never set
//   -> 8 polls, 10<=00 written, err_o[0] pulse, no done_o.

Source files
------------

// File: rtl/i2c_txn_scheduler.sv
// rtl/i2c_txn_scheduler.sv - round-robin job scheduler running scripted APB sequences on a shared I2C master
// Optional poll-timeout abort: define I2C_SCHED_TIMEOUT_EN.
module i2c_txn_scheduler #(
  parameter int NREQ     = 4,
  parameter int POLL_GAP = 16,
  parameter int TMO_CYC  = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      rnw_i,
  input  logic [7*NREQ-1:0]    dev_i,
  input  logic [2*NREQ-1:0]    nby_i,
  input  logic [32*NREQ-1:0]   wdata_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      done_o,
  output logic [NREQ-1:0]      err_o,
  output logic [31:0]          rdata_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [7:0]           paddr_o,
  output logic [7:0]           pwdata_o,
  input  logic [7:0]           prdata_i,
  input  logic                 pready_i
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = $clog2(POLL_GAP + 1);

  if (NREQ < 2 || NREQ > 8 || POLL_GAP < 1 || TMO_CYC < 1 || TMO_CYC > 65535) begin : g_bad_cfg
    $error("i2c_txn_scheduler: parameter out of range");
  end

  typedef enum logic [3:0] {
    IDLE, WR_NBY, WR_ADR, WR_TDR, WR_CFG, GAP, POLL, RD_RDR, CLR, DONE
  } state_t;
  typedef enum logic [1:0] {PH_OFF, PH_SETUP, PH_ACCESS} phase_t;

  state_t        state;
  phase_t        phase;
  logic [IW-1:0] ptr;
  logic          job_rnw;
  logic [6:0]    job_dev;
  logic [1:0]    job_nbm1;
  logic [1:0]    byte_cnt;
  logic [31:0]   job_wdata;
  logic [31:0]   rd_buf;
  logic [GW-1:0] gap_cnt;

`ifdef I2C_SCHED_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  logic [15:0] tmo_cnt;
  logic        job_abort;
`else
  assign err_o = '0;
`endif

  // Rotating-priority search starting at ptr
  logic          arb_hit;
  logic [IW-1:0] arb_idx;
  always_comb begin
    int j;
    arb_hit = 1'b0;
    arb_idx = '0;
    j = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!arb_hit && req_i[j]) begin
        arb_hit = 1'b1;
        arb_idx = IW'(j);
      end
    end
  end

  logic [1:0] nby_sel;
  assign nby_sel = nby_i[2*arb_idx +: 2];

  logic [7:0] acc_addr;
  logic [7:0] acc_wdata;
  logic       acc_write;
  always_comb begin
    acc_addr  = 8'h00;
    acc_wdata = 8'h00;
    acc_write = 1'b1;
    case (state)
      WR_NBY: acc_wdata = {6'b0, job_nbm1};
      WR_ADR: begin acc_addr = 8'h04; acc_wdata = {1'b0, job_dev}; end
      WR_TDR: begin
        acc_addr  = 8'h0C + {6'b0, byte_cnt};
        acc_wdata = job_wdata[8*byte_cnt +: 8];
      end
      WR_CFG: begin acc_addr = 8'h10; acc_wdata = {6'b0, job_rnw, 1'b1}; end
      POLL:   begin acc_addr = 8'h10; acc_write = 1'b0; end
      RD_RDR: begin acc_addr = 8'h08 + {6'b0, byte_cnt}; acc_write = 1'b0; end
      CLR:    acc_addr = 8'h10;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      phase     <= PH_OFF;
      ptr       <= '0;
      gnt_o     <= '0;
      done_o    <= '0;
      rdata_o   <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      job_rnw   <= 1'b0;
      job_dev   <= '0;
      job_nbm1  <= '0;
      job_wdata <= '0;
      rd_buf    <= '0;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
`ifdef I2C_SCHED_TIMEOUT_EN
      tmo_cnt   <= '0;
      job_abort <= 1'b0;
      err_o     <= '0;
`endif
    end else begin
      done_o <= '0;
`ifdef I2C_SCHED_TIMEOUT_EN
      err_o  <= '0;
`endif
      case (state)
        IDLE: if (arb_hit) begin
          gnt_o     <= NREQ'(1) << arb_idx;
          ptr       <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          job_rnw   <= rnw_i[arb_idx];
          job_dev   <= dev_i[7*arb_idx +: 7];
          job_nbm1  <= (nby_sel == 2'd0) ? 2'd0 : nby_sel - 2'd1;
          job_wdata <= wdata_i[32*arb_idx +: 32];
          rd_buf    <= '0;
          byte_cnt  <= '0;
`ifdef I2C_SCHED_TIMEOUT_EN
          job_abort <= 1'b0;
`endif
          state     <= WR_NBY;
        end
        // Leaving GAP launches the status read's SETUP directly, so the bus idles exactly POLL_GAP cycles
        GAP: if (gap_cnt == GW'(POLL_GAP - 1)) begin
          gap_cnt   <= '0;
          state     <= POLL;
          phase     <= PH_SETUP;
          psel_o    <= 1'b1;
          penable_o <= 1'b0;
          pwrite_o  <= 1'b0;
          paddr_o   <= 8'h10;
          pwdata_o  <= 8'h00;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        DONE: begin
          gnt_o <= '0;
          state <= IDLE;
        end
        default: case (phase)
          PH_OFF: begin
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            pwrite_o  <= acc_write;
            paddr_o   <= acc_addr;
            pwdata_o  <= acc_wdata;
            phase     <= PH_SETUP;
          end
          PH_SETUP: begin
            penable_o <= 1'b1;
            phase     <= PH_ACCESS;
          end
          default: if (pready_i) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            phase     <= PH_OFF;
            case (state)
              WR_NBY: state <= WR_ADR;
              WR_ADR: begin
                byte_cnt <= '0;
                state    <= job_rnw ? WR_CFG : WR_TDR;
              end
              WR_TDR: begin
                if (byte_cnt == job_nbm1) state <= WR_CFG;
                else byte_cnt <= byte_cnt + 1'b1;
              end
              WR_CFG: begin
                gap_cnt <= '0;
`ifdef I2C_SCHED_TIMEOUT_EN
                tmo_cnt <= '0;
`endif
                state   <= GAP;
              end
              POLL: begin
                if (prdata_i[1]) begin
                  byte_cnt <= '0;
                  state    <= job_rnw ? RD_RDR : CLR;
                end else begin
`ifdef I2C_SCHED_TIMEOUT_EN
                  if (tmo_cnt == TMO_LAST) begin
                    job_abort <= 1'b1;
                    state     <= CLR;
                  end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    state   <= GAP;
                  end
`else
                  state <= GAP;
`endif
                end
              end
              RD_RDR: begin
                rd_buf[8*byte_cnt +: 8] <= prdata_i;
                if (byte_cnt == job_nbm1) state <= CLR;
                else byte_cnt <= byte_cnt + 1'b1;
              end
              CLR: begin
                state <= DONE;
`ifdef I2C_SCHED_TIMEOUT_EN
                if (job_abort) begin
                  err_o <= gnt_o;
                end else begin
                  done_o <= gnt_o;
                  if (job_rnw) rdata_o <= rd_buf;
                end
`else
                done_o <= gnt_o;
                if (job_rnw) rdata_o <= rd_buf;
`endif
              end
              default: state <= IDLE;
            endcase
          end
        endcase
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// tb/tb_i2c_txn_scheduler.sv - directed self-checking bench for i2c_txn_scheduler with an APB I2C master model
module tb_i2c_txn_scheduler;
  localparam int NREQ = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [3:0]   req_i, rnw_i;
  logic [27:0]  dev_i;
  logic [7:0]   nby_i;
  logic [127:0] wdata_i;
  logic [3:0]   gnt_o, done_o, err_o;
  logic [31:0]  rdata_o;
  logic         psel_o, penable_o, pwrite_o;
  logic [7:0]   paddr_o, pwdata_o, prdata_i;
  logic         pready_i;

  always #5 clk_i = ~clk_i;

  i2c_txn_scheduler #(.NREQ(NREQ), .POLL_GAP(2), .TMO_CYC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .rnw_i(rnw_i), .dev_i(dev_i),
    .nby_i(nby_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i)
  );

  int total = 0;
  int bad   = 0;

  // I2C master model: logs writes, counts status reads, reports done after done_after polls
  logic [7:0]  rdr [0:2];
  logic [15:0] wlog [$];
  int  poll_cnt = 0, poll_base = 0, done_after = 2;
  int  stall_cfg = 0, stall_left = 0, stall_seen = 0, proto_bad = 0, err_seen = 0;
  bit  never_done = 1'b0;
  logic       prev_wait = 1'b0, prev_write = 1'b0;
  logic [7:0] prev_addr = 8'h00, prev_wdata = 8'h00;

  assign pready_i = (stall_left == 0);

  always_comb begin
    prdata_i = 8'h00;
    if (paddr_o == 8'h10)
      prdata_i = (!never_done && (poll_cnt - poll_base + 1 >= done_after)) ? 8'h02 : 8'h00;
    else if (paddr_o >= 8'h08 && paddr_o <= 8'h0A)
      prdata_i = rdr[paddr_o[1:0]];
  end

  always @(posedge clk_i) begin
    if (psel_o && penable_o && pready_i) begin
      if (pwrite_o) wlog.push_back({paddr_o, pwdata_o});
      else if (paddr_o == 8'h10) poll_cnt <= poll_cnt + 1;
    end
    if (psel_o && !penable_o) stall_left <= stall_cfg;
    else if (psel_o && penable_o && stall_left != 0) begin
      stall_left <= stall_left - 1;
      stall_seen++;
    end
    if (prev_wait && !(psel_o && penable_o && paddr_o == prev_addr &&
                       pwdata_o == prev_wdata && pwrite_o == prev_write))
      proto_bad++;
    if (penable_o && !psel_o) proto_bad++;
    if (|err_o) err_seen++;
    prev_wait  = psel_o && penable_o && !pready_i && !rst_i;
    prev_addr  = paddr_o;
    prev_wdata = pwdata_o;
    prev_write = pwrite_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_evt(input string tag, input int budget);
    int n;
    n = 0;
    while (done_o == 4'b0 && err_o == 4'b0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic set_job(input int k, input logic rnw, input logic [6:0] dev,
                         input logic [1:0] nby, input logic [31:0] wd);
    rnw_i[k]            = rnw;
    dev_i[7*k +: 7]     = dev;
    nby_i[2*k +: 2]     = nby;
    wdata_i[32*k +: 32] = wd;
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [15:0] exp);
    logic [15:0] v;
    v = (idx < wlog.size()) ? wlog[idx] : 16'hxxxx;
    check(tag, 32'(v), 32'(exp));
  endtask

  initial begin
    int base;
    int stall_base;
    int n;
    logic [3:0] rr_exp [0:4];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    rdr[0] = 8'h11; rdr[1] = 8'h22; rdr[2] = 8'h33;
    rst_i = 1'b1; req_i = '0; rnw_i = '0; dev_i = '0; nby_i = '0; wdata_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst_gnt",     32'(gnt_o), 32'h0);
    check("rst_done",    32'(done_o), 32'h0);
    check("rst_err",     32'(err_o), 32'h0);
    check("rst_psel",    32'(psel_o), 32'h0);
    check("rst_penable", 32'(penable_o), 32'h0);
    check("rst_rdata",   rdata_o, 32'h0);
    rst_i = 1'b0;

    // Write job: req0, dev 0x50, two bytes
    set_job(0, 1'b0, 7'h50, 2'd2, 32'h0000AABB);
    base = wlog.size(); poll_base = poll_cnt; req_i = 4'b0001;
    @(negedge clk_i);
    check("wr_gnt_early", 32'(gnt_o), 32'h1);
    wait_evt("wr_wait", 400);
    check("wr_done",  32'(done_o), 32'h1);
    check("wr_gnt",   32'(gnt_o), 32'h1);
    check("wr_rdata", rdata_o, 32'h0);
    check("wr_polls", 32'(poll_cnt - poll_base), 32'd2);
    check("wr_nwr",   32'(wlog.size() - base), 32'd6);
    check_wr("wr_nby", base + 0, 16'h0001);
    check_wr("wr_adr", base + 1, 16'h0450);
    check_wr("wr_td0", base + 2, 16'h0CBB);
    check_wr("wr_td1", base + 3, 16'h0DAA);
    check_wr("wr_cfg", base + 4, 16'h1001);
    check_wr("wr_clr", base + 5, 16'h1000);
    req_i = 4'b0;
    @(negedge clk_i);
    check("wr_done_pulse", 32'(done_o), 32'h0);
    check("wr_gnt_drop",   32'(gnt_o), 32'h0);

    // Read job: req1, three bytes 11,22,33
    set_job(1, 1'b1, 7'h21, 2'd3, 32'h0);
    base = wlog.size(); poll_base = poll_cnt; req_i = 4'b0010;
    wait_evt("rd_wait", 400);
    check("rd_done",  32'(done_o), 32'h2);
    check("rd_rdata", rdata_o, 32'h00332211);
    check("rd_nwr",   32'(wlog.size() - base), 32'd4);
    check_wr("rd_nby", base + 0, 16'h0002);
    check_wr("rd_adr", base + 1, 16'h0421);
    check_wr("rd_cfg", base + 2, 16'h1003);
    check_wr("rd_clr", base + 3, 16'h1000);
    req_i = 4'b0;
    @(negedge clk_i);

    // Reset while polling a job that never finishes
    set_job(0, 1'b0, 7'h50, 2'd1, 32'h77);
    never_done = 1'b1; poll_base = poll_cnt; req_i = 4'b0001;
    n = 0;
    while (poll_cnt - poll_base < 1 && n < 400) begin @(negedge clk_i); n++; end
    check("rp_reach_poll", 32'(n < 400), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rp_gnt",  32'(gnt_o), 32'h0);
    check("rp_done", 32'(done_o), 32'h0);
    check("rp_psel", 32'(psel_o), 32'h0);
    rst_i = 1'b0; req_i = 4'b0; never_done = 1'b0;
    set_job(2, 1'b0, 7'h12, 2'd1, 32'h5A);
    base = wlog.size(); poll_base = poll_cnt; req_i = 4'b0100;
    @(negedge clk_i);
    check("rp2_gnt", 32'(gnt_o), 32'h4);
    wait_evt("rp2_wait", 400);
    check("rp2_done",  32'(done_o), 32'h4);
    check("rp2_rdata", rdata_o, 32'h0);
    check("rp2_nwr",   32'(wlog.size() - base), 32'd5);
    check_wr("rp2_td0", base + 2, 16'h0C5A);
    req_i = 4'b0;
    @(negedge clk_i);

    // Round robin from a freshly reset pointer, all requesters held
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < NREQ; k++) set_job(k, 1'b0, 7'(8'h30 + k), 2'd1, 32'(k));
    req_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_evt($sformatf("rr_wait%0d", i), 400);
      check($sformatf("rr_order%0d", i), 32'(done_o), 32'(rr_exp[i]));
      if (i == 4) req_i = 4'b0;
      @(negedge clk_i);
    end

    // APB stall: every ACCESS held 5 cycles
    stall_cfg = 5; stall_base = stall_seen;
    rdr[0] = 8'h44; rdr[1] = 8'h55; rdr[2] = 8'h66;
    set_job(3, 1'b1, 7'h3C, 2'd2, 32'h0);
    base = wlog.size(); poll_base = poll_cnt; req_i = 4'b1000;
    wait_evt("st_wait", 1500);
    check("st_done",   32'(done_o), 32'h8);
    check("st_rdata",  rdata_o, 32'h00005544);
    check("st_stalls", 32'(stall_seen - stall_base), 32'd40);
    check_wr("st_nby", base + 0, 16'h0001);
    check_wr("st_adr", base + 1, 16'h043C);
    check_wr("st_cfg", base + 2, 16'h1003);
    check_wr("st_clr", base + 3, 16'h1000);
    req_i = 4'b0; stall_cfg = 0;
    @(negedge clk_i);

`ifdef I2C_SCHED_TIMEOUT_EN
    set_job(0, 1'b0, 7'h50, 2'd1, 32'h01);
    never_done = 1'b1; base = wlog.size(); poll_base = poll_cnt; req_i = 4'b0001;
    wait_evt("to_wait", 2000);
    check("to_err",   32'(err_o), 32'h1);
    check("to_done",  32'(done_o), 32'h0);
    check("to_polls", 32'(poll_cnt - poll_base), 32'd8);
    check_wr("to_clr", wlog.size() - 1, 16'h1000);
    check("to_rdata", rdata_o, 32'h00005544);
    req_i = 4'b0; never_done = 1'b0;
    @(negedge clk_i);
    check("err_count", 32'(err_seen), 32'd1);
`else
    check("err_never", 32'(err_seen), 32'd0);
`endif
    check("apb_protocol", 32'(proto_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
